fetch_unit: RTL

- Program-counter and fetch-sequencing stage directly upstream of the instruction decoder.
- Holds the PC and emits the instruction-memory address each cycle.
- Consumes the decoder's branch/taken/halt flags to pick the next PC: sequential increment, branch target from an internal lookup table, or hold on halt.
- Provides the start/done handshake with the testbench/host.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// PC / fetch sequencer feeding the decoder: start/halt handshake and branch-target LUT.
// Optional executed-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              branch,
  input  logic              taken,
  input  logic              halt,
  input  logic [LUT_AW-1:0] target_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic [15:0]       cycle_count
);

  localparam int LutDepth = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [PC_W-1:0] pcNext;
  logic            accept;
  logic [PC_W-1:0] lut [LutDepth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

  // Nonblocking update gives read-before-write for a same-cycle branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LutDepth; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          pcNext    = start_addr;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          pcNext = start_addr;
          accept = 1'b1;
        end else if (halt) begin
          stateNext = HALTED;
        end else if (branch && taken) begin
          pcNext = lut[target_idx];
        end else begin
          pcNext = pc + PC_W'(1);
        end
      end
      HALTED: begin
        if (start) begin
          stateNext = RUN;
          pcNext    = start_addr;
          accept    = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign running = (state == RUN);
  assign done    = (state == HALTED);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycCnt <= '0;
    end else if (accept) begin
      cycCnt <= '0;
    end else if (state == RUN && cycCnt != 16'hFFFF) begin
      cycCnt <= cycCnt + 16'd1;
    end
  end

  assign cycle_count = cycCnt;
`else
  logic unusedAccept;
  assign unusedAccept = accept;
  assign cycle_count  = '0;
`endif

endmodule
